// File: rtl/scie_issue_sequencer.sv
// rtl/scie_issue_sequencer.sv - SCIE initiator: command FIFO, credit-limited issue, fixed-latency capture, in-order response FIFO
module scie_issue_sequencer #(
    parameter int XLEN      = 32,
    parameter int LATENCY   = 1,
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            io_cmd_valid,
    output logic            io_cmd_ready,
    input  logic [31:0]     io_cmd_insn,
    input  logic [XLEN-1:0] io_cmd_rs1,
    input  logic [XLEN-1:0] io_cmd_rs2,
    input  logic            io_drain,
    output logic            io_scie_valid,
    output logic [31:0]     io_scie_insn,
    output logic [XLEN-1:0] io_scie_rs1,
    output logic [XLEN-1:0] io_scie_rs2,
    input  logic [XLEN-1:0] io_scie_rd,
    output logic            io_rsp_valid,
    input  logic            io_rsp_ready,
    output logic [XLEN-1:0] io_rsp_data,
    output logic            io_busy
);
    localparam int CPW = $clog2(CMD_DEPTH);
    localparam int RPW = $clog2(RSP_DEPTH);
    localparam int CCW = CPW + 1;
    localparam int RCW = RPW + 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_STALL  = 2'd2;

    logic [31:0]     cmd_insn_mem [CMD_DEPTH];
    logic [XLEN-1:0] cmd_rs1_mem  [CMD_DEPTH];
    logic [XLEN-1:0] cmd_rs2_mem  [CMD_DEPTH];
    logic [XLEN-1:0] rsp_mem      [RSP_DEPTH];

    logic [CPW-1:0]     cmd_wr_ptr, cmd_rd_ptr;
    logic [CCW-1:0]     cmd_count, cmd_count_nx;
    logic [RPW-1:0]     rsp_wr_ptr, rsp_rd_ptr;
    logic [RCW-1:0]     rsp_count, rsp_count_nx;
    logic [RCW-1:0]     inflight, inflight_nx;
    logic [LATENCY-1:0] cap_pipe;
    logic [1:0]         state, state_nx;

    logic cmd_full, cmd_push, credit_ok, issue, bypass, cmd_pop, cmd_write, capture, rsp_pop;

    // Ready is gated by reset itself so it reads 0 for the whole time reset is held.
    assign cmd_full     = (cmd_count == CCW'(CMD_DEPTH));
    assign io_cmd_ready = reset && !cmd_full && !io_drain;
    assign cmd_push     = io_cmd_valid && io_cmd_ready;
    assign credit_ok    = (({1'b0, inflight} + {1'b0, rsp_count}) < (RCW + 1)'(RSP_DEPTH));
    // An empty FIFO lets the incoming command go straight to the issue registers.
    assign issue        = ((cmd_count != '0) || cmd_push) && credit_ok;
    assign bypass       = issue && (cmd_count == '0);
    assign cmd_pop      = issue && !bypass;
    assign cmd_write    = cmd_push && !bypass;
    assign capture      = cap_pipe[LATENCY-1];
    assign io_rsp_valid = (rsp_count != '0);
    assign rsp_pop      = io_rsp_valid && io_rsp_ready;
    assign io_rsp_data  = io_rsp_valid ? rsp_mem[rsp_rd_ptr] : '0;
    assign io_busy      = (state != ST_IDLE) || (rsp_count != '0);

    always_comb begin
        cmd_count_nx = cmd_count;
        if (cmd_write && !cmd_pop)
            cmd_count_nx = cmd_count + CCW'(1);
        else if (!cmd_write && cmd_pop)
            cmd_count_nx = cmd_count - CCW'(1);

        inflight_nx = inflight;
        if (issue && !capture)
            inflight_nx = inflight + RCW'(1);
        else if (!issue && capture)
            inflight_nx = inflight - RCW'(1);

        rsp_count_nx = rsp_count;
        if (capture && !rsp_pop)
            rsp_count_nx = rsp_count + RCW'(1);
        else if (!capture && rsp_pop)
            rsp_count_nx = rsp_count - RCW'(1);

        if ((cmd_count_nx == '0) && (inflight_nx == '0))
            state_nx = ST_IDLE;
        else if ((cmd_count_nx != '0) &&
                 (({1'b0, inflight_nx} + {1'b0, rsp_count_nx}) >= (RCW + 1)'(RSP_DEPTH)))
            state_nx = ST_STALL;
        else
            state_nx = ST_ACTIVE;
    end

    always_ff @(posedge clock) begin
        if (cmd_write) begin
            cmd_insn_mem[cmd_wr_ptr] <= io_cmd_insn;
            cmd_rs1_mem[cmd_wr_ptr]  <= io_cmd_rs1;
            cmd_rs2_mem[cmd_wr_ptr]  <= io_cmd_rs2;
        end
        if (capture)
            rsp_mem[rsp_wr_ptr] <= io_scie_rd;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cmd_wr_ptr    <= '0;
            cmd_rd_ptr    <= '0;
            cmd_count     <= '0;
            rsp_wr_ptr    <= '0;
            rsp_rd_ptr    <= '0;
            rsp_count     <= '0;
            inflight      <= '0;
            cap_pipe      <= '0;
            state         <= ST_IDLE;
            io_scie_valid <= 1'b0;
            io_scie_insn  <= '0;
            io_scie_rs1   <= '0;
            io_scie_rs2   <= '0;
        end else begin
            if (cmd_write)
                cmd_wr_ptr <= cmd_wr_ptr + CPW'(1);
            if (cmd_pop)
                cmd_rd_ptr <= cmd_rd_ptr + CPW'(1);
            if (capture)
                rsp_wr_ptr <= rsp_wr_ptr + RPW'(1);
            if (rsp_pop)
                rsp_rd_ptr <= rsp_rd_ptr + RPW'(1);
            cmd_count     <= cmd_count_nx;
            rsp_count     <= rsp_count_nx;
            inflight      <= inflight_nx;
            state         <= state_nx;
            // Stage k high means the issue happened k+1 cycles ago; the last stage marks io_scie_rd valid.
            cap_pipe      <= LATENCY'({cap_pipe, io_scie_valid});
            io_scie_valid <= issue;
            if (!issue) begin
                io_scie_insn <= '0;
                io_scie_rs1  <= '0;
                io_scie_rs2  <= '0;
            end else if (bypass) begin
                io_scie_insn <= io_cmd_insn;
                io_scie_rs1  <= io_cmd_rs1;
                io_scie_rs2  <= io_cmd_rs2;
            end else begin
                io_scie_insn <= cmd_insn_mem[cmd_rd_ptr];
                io_scie_rs1  <= cmd_rs1_mem[cmd_rd_ptr];
                io_scie_rs2  <= cmd_rs2_mem[cmd_rd_ptr];
            end
        end
    end
endmodule
